score_bcd_converter: RTL and testbench



---
 rtl/score_bcd_converter_pkg.sv | 26 ++
 rtl/score_bcd_converter_digit_adjust.sv | 15 +
 rtl/score_bcd_converter.sv | 138 +++++++++++++
 tb/tb_score_bcd_converter.sv | 196 +++++++++++++++++++
 4 files changed

// File: rtl/score_bcd_converter_pkg.sv
// score_bcd_converter_pkg
//   Shared constants, state encoding and digit-adjust helper for the
//   iterative binary-to-BCD score converter.
//   Contents:
//     SCORE_BIN_WIDTH / SCORE_DIGITS : default converter geometry
//     bcd_state_t                    : 2-bit FSM encoding (IDLE/SHIFT/FINISH)
//     bcd_adjust_nibble()            : shift-and-add-3 correction of one digit
package score_bcd_converter_pkg;

  localparam int SCORE_BIN_WIDTH = 20;
  localparam int SCORE_DIGITS    = 6;

  typedef enum logic [1:0] {
    BCD_IDLE   = 2'd0,
    BCD_SHIFT  = 2'd1,
    BCD_FINISH = 2'd2
  } bcd_state_t;

  // A digit of 5 or more would become >= 10 after the coming doubling,
  // so it is pre-biased by 3 to make the doubled value carry correctly.
  // Plain 4-bit add: no carry propagates into the next digit.
  function automatic logic [3:0] bcd_adjust_nibble(input logic [3:0] digit);
    return (digit >= 4'd5) ? (digit + 4'd3) : digit;
  endfunction

endpackage

// File: rtl/score_bcd_converter_digit_adjust.sv
// bcd_digit_adjust
//   One BCD digit's add-3 correction, applied before each left shift.
//   Ports:
//     digit    in  4 : current work digit
//     adjusted out 4 : digit + 3 when digit >= 5, otherwise digit
module bcd_digit_adjust
  import score_bcd_converter_pkg::*;
(
  input  logic [3:0] digit,
  output logic [3:0] adjusted
);

  assign adjusted = bcd_adjust_nibble(digit);

endmodule

// File: rtl/score_bcd_converter.sv
// score_bcd_converter
//   Iterative binary-to-BCD converter (shift-and-add-3), one shift per clock.
//   A conversion started with `start` completes BIN_WIDTH+1 cycles later with
//   a one-cycle `done` pulse; `bcd_out` / `overflow` hold the last completed
//   result so the display never shows a partially converted value.
//
//   Parameters:
//     BIN_WIDTH (>= 4) : binary input width
//     DIGITS    (>= 1) : number of BCD output digits
//   Ports:
//     clk      in  1           : conversion clock
//     reset    in  1           : asynchronous, active-high reset
//     start    in  1           : request conversion of bin_in (ignored while busy)
//     bin_in   in  BIN_WIDTH   : unsigned value, captured when start is accepted
//     busy     out 1           : conversion in progress (state != IDLE)
//     done     out 1           : one-cycle pulse, bcd_out/overflow updated with it
//     bcd_out  out 4*DIGITS    : packed BCD, digit i at [4i+3:4i], units at [3:0]
//     overflow out 1           : last converted value was >= 10^DIGITS
//
//   Build option:
//     SCORE_BCD_SATURATE_EN : when defined, an overflowing value is shown as
//                             all nines; otherwise the value mod 10^DIGITS
//                             is shown. overflow is reported in both builds.
module score_bcd_converter
  import score_bcd_converter_pkg::*;
#(
  parameter int BIN_WIDTH = SCORE_BIN_WIDTH,
  parameter int DIGITS    = SCORE_DIGITS
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  start,
  input  logic [BIN_WIDTH-1:0]  bin_in,
  output logic                  busy,
  output logic                  done,
  output logic [4*DIGITS-1:0]   bcd_out,
  output logic                  overflow
);

  localparam int WORK_W = 4 * DIGITS;
  localparam int CNT_W  = $clog2(BIN_WIDTH + 1);

  bcd_state_t            state_reg;
  logic [WORK_W-1:0]     work_reg;
  logic [BIN_WIDTH-1:0]  shift_reg;
  logic [CNT_W-1:0]      cnt_reg;
  logic                  carry_reg;
  logic                  done_reg;
  logic [WORK_W-1:0]     bcd_reg;
  logic                  overflow_reg;

  logic [WORK_W-1:0]     work_adj;
  logic [WORK_W-1:0]     work_shifted;
  logic [WORK_W-1:0]     finish_bcd;

  // Per-digit add-3 correction of the current work register.
  generate
    for (genvar gi = 0; gi < DIGITS; gi++) begin : g_adjust
      bcd_digit_adjust u_adjust (
        .digit    (work_reg[4*gi +: 4]),
        .adjusted (work_adj[4*gi +: 4])
      );
    end
  endgenerate

  // {work, shift} shifted left by one: the top binary bit enters the units
  // digit, and the bit leaving the top digit is folded into the sticky carry.
  assign work_shifted = {work_adj[WORK_W-2:0], shift_reg[BIN_WIDTH-1]};

`ifdef SCORE_BCD_SATURATE_EN
  logic [WORK_W-1:0] all_nines;

  generate
    for (genvar gi = 0; gi < DIGITS; gi++) begin : g_nines
      assign all_nines[4*gi +: 4] = 4'd9;
    end
  endgenerate

  assign finish_bcd = carry_reg ? all_nines : work_reg;
`else
  // Dropping the carried-out bits leaves the value modulo 10^DIGITS.
  assign finish_bcd = work_reg;
`endif

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_reg    <= BCD_IDLE;
      work_reg     <= '0;
      shift_reg    <= '0;
      cnt_reg      <= '0;
      carry_reg    <= 1'b0;
      done_reg     <= 1'b0;
      bcd_reg      <= '0;
      overflow_reg <= 1'b0;
    end else begin
      done_reg <= 1'b0;
      case (state_reg)
        BCD_IDLE: begin
          if (start) begin
            shift_reg <= bin_in;
            work_reg  <= '0;
            carry_reg <= 1'b0;
            cnt_reg   <= CNT_W'(BIN_WIDTH);
            state_reg <= BCD_SHIFT;
          end
        end

        BCD_SHIFT: begin
          work_reg  <= work_shifted;
          shift_reg <= {shift_reg[BIN_WIDTH-2:0], 1'b0};
          carry_reg <= carry_reg | work_adj[WORK_W-1];
          cnt_reg   <= cnt_reg - CNT_W'(1);
          // Counter reaching 1 on this edge means this was the last shift.
          if (cnt_reg == CNT_W'(1)) begin
            state_reg <= BCD_FINISH;
          end
        end

        BCD_FINISH: begin
          bcd_reg      <= finish_bcd;
          overflow_reg <= carry_reg;
          done_reg     <= 1'b1;
          state_reg    <= BCD_IDLE;
        end

        default: begin
          state_reg <= BCD_IDLE;
        end
      endcase
    end
  end

  assign busy     = (state_reg != BCD_IDLE);
  assign done     = done_reg;
  assign bcd_out  = bcd_reg;
  assign overflow = overflow_reg;

endmodule

// File: tb/tb_score_bcd_converter.sv
// tb_score_bcd_converter
//   Scoreboard bench: each accepted conversion pushes its expected digits,
//   overflow flag and acceptance cycle; a monitor pops and compares on done.
module tb_score_bcd_converter;

  localparam int BW = 20;
  localparam int D  = 6;

  logic          clk;
  logic          reset;
  logic          start;
  logic [BW-1:0] bin_in;
  logic          busy;
  logic          done;
  logic [4*D-1:0] bcd_out;
  logic          overflow;

  score_bcd_converter #(.BIN_WIDTH(BW), .DIGITS(D)) dut (
    .clk      (clk),
    .reset    (reset),
    .start    (start),
    .bin_in   (bin_in),
    .busy     (busy),
    .done     (done),
    .bcd_out  (bcd_out),
    .overflow (overflow)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;
  int cyc    = 0;
  int dones  = 0;
  int pushes = 0;

  logic [4*D-1:0] exp_bcd_q[$];
  bit             exp_ovf_q[$];
  int             acc_q[$];

  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // Reference: decimal digits of the value by plain division.
  function automatic int pow10(input int n);
    int r = 1;
    for (int i = 0; i < n; i++) r = r * 10;
    return r;
  endfunction

  function automatic logic [4*D-1:0] ref_bcd(input int v);
    logic [4*D-1:0] r;
    int x;
    r = '0;
    if (v >= pow10(D)) begin
`ifdef SCORE_BCD_SATURATE_EN
      x = pow10(D) - 1;
`else
      x = v % pow10(D);
`endif
    end else begin
      x = v;
    end
    for (int i = 0; i < D; i++) begin
      r[4*i +: 4] = 4'(x % 10);
      x = x / 10;
    end
    return r;
  endfunction

  // Monitor: compare every done against the oldest outstanding expectation.
  always @(negedge clk) begin
    if (done) begin
      dones++;
      if (exp_bcd_q.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL unexpected_done: got done=1, expected no done (cycle %0d)", cyc);
      end else begin
        logic [4*D-1:0] eb;
        bit eo;
        int ac;
        eb = exp_bcd_q.pop_front();
        eo = exp_ovf_q.pop_front();
        ac = acc_q.pop_front();
        check("bcd_out", 32'(bcd_out), 32'(eb));
        check("overflow", 32'(overflow), 32'(eo));
        check("latency", 32'(cyc - ac), 32'(BW + 1));
        check("busy_in_done_cycle", 32'(busy), 32'd0);
        $display("done: bcd_out=0x%06h overflow=%0d expected 0x%06h/%0d latency=%0d",
                 bcd_out, overflow, eb, eo, cyc - ac);
      end
    end
  end

  // Wait for IDLE (busy low, which includes the done cycle), then issue start.
  task automatic start_conv(input int v, input bit expect_result);
    int t;
    t = 0;
    @(negedge clk);
    while (busy && t < 100) begin
      @(negedge clk);
      t++;
    end
    if (busy) begin
      checks++;
      errors++;
      $display("FAIL idle_timeout: busy still 1 after %0d cycles, expected 0", t);
    end
    start  = 1'b1;
    bin_in = BW'(v);
    if (expect_result) begin
      exp_bcd_q.push_back(ref_bcd(v));
      exp_ovf_q.push_back(v >= pow10(D));
      acc_q.push_back(cyc + 1);
      pushes++;
    end
    @(posedge clk);
    #1;
    start = 1'b0;
    check("busy_after_start", 32'(busy), 32'd1);
  endtask

  task automatic check_idle_outputs(input string tag);
    check({tag, "_busy"}, 32'(busy), 32'd0);
    check({tag, "_done"}, 32'(done), 32'd0);
    check({tag, "_bcd_out"}, 32'(bcd_out), 32'd0);
    check({tag, "_overflow"}, 32'(overflow), 32'd0);
  endtask

  initial begin
    int t;
    reset  = 1'b1;
    start  = 1'b0;
    bin_in = '0;
    repeat (2) @(negedge clk);
    check_idle_outputs("in_reset");
    reset = 1'b0;
    @(negedge clk);
    check_idle_outputs("after_reset");

    // Directed values, including the overflow boundary.
    start_conv(0, 1'b1);
    start_conv(123456, 1'b1);
    start_conv(999999, 1'b1);
    start_conv(1000000, 1'b1);
    start_conv((1 << BW) - 1, 1'b1);

    // A start during a conversion is dropped; one on the done cycle is taken.
    start_conv(42, 1'b1);
    repeat (4) @(negedge clk);
    start  = 1'b1;
    bin_in = BW'(77);
    @(posedge clk);
    #1;
    start = 1'b0;
    start_conv(77, 1'b1);

    // Reset in mid-conversion aborts without a done.
    start_conv(500000, 1'b0);
    repeat (9) @(negedge clk);
    reset = 1'b1;
    @(negedge clk);
    reset = 1'b0;
    check_idle_outputs("abort_reset");
    repeat (25) @(negedge clk);
    check_idle_outputs("after_abort");
    start_conv(31, 1'b1);

    // Random sweep, back-to-back.
    for (int i = 0; i < 1000; i++) begin
      start_conv(int'($urandom_range(0, (1 << BW) - 1)), 1'b1);
    end

    t = 0;
    while (exp_bcd_q.size() != 0 && t < 100) begin
      @(negedge clk);
      t++;
    end
    check("outstanding_results", 32'(exp_bcd_q.size()), 32'd0);
    repeat (3) @(negedge clk);
    check("done_count", 32'(dones), 32'(pushes));

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
